// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter feeding a single UART transmitter: one requester's byte is
// latched per grant and serialised as start + DATA_BITS (LSB first) + STOP_BITS.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           baud_tick,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*DATA_BITS-1:0]   data_in,
    output logic [NUM_REQ-1:0]             ack,
    output logic [$clog2(NUM_REQ)-1:0]     grant_id,
    output logic                           busy,
    output logic                           done,
    output logic                           tx
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DATA_BITS);
    localparam int SW = (STOP_BITS > 1) ? $clog2(STOP_BITS) : 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALIGN = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_STOP  = 3'd4;

    logic [2:0]           state_q, state_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        last_q, last_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [SW-1:0]        stop_cnt_q, stop_cnt_d;
    logic [GW-1:0]        win;

    // Walk from the farthest to the nearest candidate so the nearest asserting
    // requester after last_grant overwrites the others.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                              input logic [GW-1:0] last);
        logic [GW-1:0] pick;
        int            idx;
        pick = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_REQ;
            if (r[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        ack_d      = '0;
        grant_d    = grant_q;
        last_d     = last_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        win        = rr_pick(req, last_q);
        case (state_q)
            // A tick on the grant edge is deliberately ignored; ALIGN waits for the next one.
            S_IDLE: begin
                if (|req) begin
                    shift_d    = data_in[int'(win)*DATA_BITS +: DATA_BITS];
                    ack_d[win] = 1'b1;
                    grant_d    = win;
                    last_d     = win;
                    busy_d     = 1'b1;
                    state_d    = S_ALIGN;
                end
            end
            S_ALIGN: begin
                if (baud_tick) begin
                    tx_d    = 1'b0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_tick) begin
                    tx_d      = shift_q[0];
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_tick) begin
                    if (bit_cnt_q == CW'(DATA_BITS-1)) begin
                        tx_d       = 1'b1;
                        stop_cnt_d = '0;
                        state_d    = S_STOP;
                    end else begin
                        shift_d   = shift_q >> 1;
                        tx_d      = shift_q[1];
                        bit_cnt_d = bit_cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (baud_tick) begin
                    if (stop_cnt_q == SW'(STOP_BITS-1)) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stop_cnt_d = stop_cnt_q + SW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Asynchronous reset forces the line idle at once, dropping any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_q      <= '0;
            grant_q    <= '0;
            last_q     <= GW'(NUM_REQ-1);
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_q      <= ack_d;
            grant_q    <= grant_d;
            last_q     <= last_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
        end
    end

    assign ack      = ack_q;
    assign grant_id = grant_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign tx       = tx_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed and randomized checks of uart_tx_arbiter against a frame/round-robin reference model.
module tb_uart_tx_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n     = 1'b0;
    logic           baud_tick = 1'b0;
    logic [N-1:0]   req_a     = '0;
    logic [N-1:0]   req_b     = '0;
    logic [N*8-1:0] data_a    = '0;
    logic [N*7-1:0] data_b    = '0;
    logic [N-1:0]   ack_a, ack_b;
    logic [1:0]     gid_a, gid_b;
    logic           busy_a, busy_b, done_a, done_b, tx_a, tx_b;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(8), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req(req_a), .data_in(data_a),
        .ack(ack_a), .grant_id(gid_a), .busy(busy_a), .done(done_a), .tx(tx_a));

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(7), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .baud_tick(baud_tick), .req(req_b), .data_in(data_b),
        .ack(ack_b), .grant_id(gid_b), .busy(busy_b), .done(done_b), .tx(tx_b));

    logic         sel = 1'b0;
    logic [N-1:0] ack_m;
    logic [1:0]   gid_m;
    logic         busy_m, done_m, tx_m;
    assign ack_m  = sel ? ack_b  : ack_a;
    assign gid_m  = sel ? gid_b  : gid_a;
    assign busy_m = sel ? busy_b : busy_a;
    assign done_m = sel ? done_b : done_a;
    assign tx_m   = sel ? tx_b   : tx_a;

    int tests = 0;
    int fails = 0;
    int phase = 0;
    bit tick_en = 1'b1;
    bit last_tick = 1'b0;
    int model_last = N - 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: baud_tick every 4th clock while enabled, outputs sampled 1ns after the edge.
    task automatic step();
        baud_tick = tick_en && (phase == 3);
        phase = (phase + 1) % 4;
        @(posedge clk);
        #1;
        last_tick = baud_tick;
    endtask

    function automatic int rr_model(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++)
            if (r[(last + k) % N]) return (last + k) % N;
        return -1;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        model_last = N - 1;
    endtask

    task automatic wait_grant(input int exp_id, input string tag);
        int n;
        n = 0;
        while (ack_m == '0 && n < 40) begin
            step();
            n++;
        end
        check({tag, "_ack"}, 32'(ack_m), 32'(1) << exp_id);
        check({tag, "_gid"}, 32'(gid_m), 32'(exp_id));
        check({tag, "_busy"}, 32'(busy_m), 32'd1);
        check({tag, "_tx_idle"}, 32'(tx_m), 32'd1);
        model_last = exp_id;
    endtask

    // Follows one frame from just after its ack; stall_at/abort_at name the tick number
    // (1 = start bit) after which ticks pause for 50 clk or reset is pulsed.
    task automatic expect_frame(input string tag, input int id, input logic [7:0] data,
                                input int db, input int sb, input int stall_at, input int abort_at);
        logic [15:0] got, exp;
        int nt, nbits, done_tick, acks, dones, cyc;
        bit held, aborted;
        logic hold_val;
        got = '0; exp = '0;
        nt = 0; nbits = 1 + db + sb; done_tick = -1; acks = 0; dones = 0; cyc = 0;
        aborted = 1'b0;
        for (int i = 0; i < db; i++) exp[1 + i] = data[i];
        for (int i = 0; i < sb; i++) exp[1 + db + i] = 1'b1;
        while (dones == 0 && cyc < 400 && !aborted) begin
            step();
            cyc++;
            if (ack_m != '0) acks++;
            if (last_tick) begin
                nt++;
                if (nt <= nbits) got[nt - 1] = tx_m;
            end
            if (done_m) begin
                dones++;
                done_tick = nt;
                check({tag, "_busy_end"}, 32'(busy_m), 32'd0);
                check({tag, "_tx_end"}, 32'(tx_m), 32'd1);
            end
            if (last_tick && nt == stall_at) begin
                tick_en = 1'b0;
                hold_val = tx_m;
                held = 1'b1;
                for (int s = 0; s < 50; s++) begin
                    step();
                    if (tx_m !== hold_val || done_m !== 1'b0 || busy_m !== 1'b1) held = 1'b0;
                end
                check({tag, "_stall_hold"}, 32'(held), 32'd1);
                tick_en = 1'b1;
            end
            if (last_tick && nt == abort_at) begin
                check({tag, "_pre_abort_tx"}, 32'(tx_m), 32'(exp[nt - 1]));
                #2 rst_n = 1'b0;
                #1;
                check({tag, "_abort_tx"}, 32'(tx_m), 32'd1);
                check({tag, "_abort_busy"}, 32'(busy_m), 32'd0);
                for (int s = 0; s < 3; s++) begin
                    step();
                    if (done_m) dones++;
                end
                rst_n = 1'b1;
                model_last = N - 1;
                for (int s = 0; s < 6; s++) begin
                    step();
                    if (done_m) dones++;
                    if (ack_m != '0 || busy_m) acks++;
                end
                check({tag, "_abort_no_done"}, 32'(dones), 32'd0);
                check({tag, "_abort_no_grant"}, 32'(acks), 32'd0);
                aborted = 1'b1;
            end
        end
        if (!aborted) begin
            check({tag, "_bits"}, 32'(got), 32'(exp));
            check({tag, "_done_tick"}, 32'(done_tick), 32'(nbits + 1));
            check({tag, "_done_cnt"}, 32'(dones), 32'd1);
            check({tag, "_no_ack"}, 32'(acks), 32'd0);
            check({tag, "_gid_hold"}, 32'(gid_m), 32'(id));
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [N-1:0] r;
        int w;

        rst_n = 1'b0;
        repeat (3) step();
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #0;
            check("rst_tx", 32'(tx_m), 32'd1);
            check("rst_busy", 32'(busy_m), 32'd0);
            check("rst_done", 32'(done_m), 32'd0);
            check("rst_ack", 32'(ack_m), 32'd0);
            check("rst_gid", 32'(gid_m), 32'd0);
        end
        sel = 1'b0;
        rst_n = 1'b1;
        step();

        // Single frame of 0xA5 from requester 0.
        data_a[7:0] = 8'hA5;
        req_a = 4'b0001;
        wait_grant(0, "single");
        req_a = '0;
        expect_frame("single", 0, 8'hA5, 8, 1, 0, 0);

        // Round robin with all requests held, starting from reset priority.
        do_reset();
        data_a = {8'h44, 8'h33, 8'h22, 8'h11};
        req_a = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            w = rr_model(req_a, model_last);
            wait_grant(w, "rr");
            expect_frame("rr", w, data_a[w*8 +: 8], 8, 1, 0, 0);
        end
        req_a = '0;
        step();

        // Request raised in the same cycle as a baud tick.
        d = 8'($urandom_range(0, 255));
        data_a[15:8] = d;
        while (phase != 3) step();
        req_a = 4'b0010;
        wait_grant(rr_model(req_a, model_last), "tick_grant");
        req_a = '0;
        expect_frame("tick_grant", 1, d, 8, 1, 0, 0);

        // Baud ticks stalled mid-data.
        d = 8'($urandom_range(0, 255));
        data_a[31:24] = d;
        req_a = 4'b1000;
        wait_grant(rr_model(req_a, model_last), "stall");
        req_a = '0;
        expect_frame("stall", 3, d, 8, 1, 4, 0);

        // Reset during data bit 3, then a fresh grant to requester 2.
        d = 8'($urandom_range(0, 255)) & 8'hF7;
        data_a[7:0] = d;
        req_a = 4'b0001;
        wait_grant(rr_model(req_a, model_last), "abort");
        req_a = '0;
        expect_frame("abort", 0, d, 8, 1, 0, 5);
        d = 8'($urandom_range(0, 255));
        data_a[23:16] = d;
        req_a = 4'b0100;
        wait_grant(2, "post_abort");
        req_a = '0;
        expect_frame("post_abort", 2, d, 8, 1, 0, 0);

        // Random request mixes; data and requests scrambled while each frame is in flight.
        for (int it = 0; it < 8; it++) begin
            r = 4'($urandom_range(1, 15));
            req_a = r;
            data_a = 32'($urandom);
            w = rr_model(r, model_last);
            wait_grant(w, "rand");
            d = data_a[w*8 +: 8];
            data_a = 32'($urandom);
            req_a = 4'($urandom_range(0, 15));
            expect_frame("rand", w, d, 8, 1, 0, 0);
        end
        req_a = '0;
        step();

        // Seven data bits, two stop bits.
        sel = 1'b1;
        data_b[6:0] = 7'h7F;
        req_b = 4'b0001;
        wait_grant(0, "db7sb2");
        req_b = '0;
        expect_frame("db7sb2", 0, 8'h7F, 7, 2, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
- NUM_REQ, 4: number of requesters, 2..8.
- DATA_BITS, 8: data bits per frame, 5..8.
- STOP_BITS, 1: stop bits per frame, 1..2.

REQ-002 Ports SHALL be, one per line:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- baud_tick  input  1  one-clk pulse per bit period, from the team baud generator.
- req  input  NUM_REQ  per-requester level request.
- data_in  input  NUM_REQ*DATA_BITS  requester i byte at bits [i*DATA_BITS +: DATA_BITS].
- ack  output  NUM_REQ  one-clk pulse: byte of requester i latched.
- grant_id  output  clog2(NUM_REQ)  index of requester currently being served.
- busy  output  1  high from latch cycle until frame end.
- done  output  1  one-clk pulse at end of last stop bit.
- tx  output  1  serial line, idle high.

Function
REQ-003 FSM states SHALL be IDLE, ALIGN, START, DATA, STOP. All outputs are registered.
REQ-004 IDLE with req != 0 SHALL select a winner round-robin and act on the same clock edge:
- search starts at (last_grant+1) mod NUM_REQ;
- latch the winner's data_in slice into the shift register;
- ack[winner] = 1 for exactly one cycle; grant_id = winner; last_grant = winner;
- busy = 1; go to ALIGN.
REQ-005 req SHALL be ignored in every state other than IDLE. ack SHALL never assert outside the IDLE→ALIGN edge.
REQ-006 A baud_tick coinciding with the IDLE grant edge SHALL NOT be consumed. ALIGN waits for the next baud_tick.
REQ-007 On baud_tick, each state SHALL act as follows:
- ALIGN: tx = 0; go to START.
- START: tx = shift[0] (LSB first); bit_cnt = 0; go to DATA.
- DATA with bit_cnt < DATA_BITS-1: shift right; tx = next bit; bit_cnt + 1.
- DATA with bit_cnt = DATA_BITS-1: tx = 1; stop_cnt = 0; go to STOP.
- STOP with stop_cnt < STOP_BITS-1: stop_cnt + 1.
- STOP with stop_cnt = STOP_BITS-1: done = 1 for one cycle; busy = 0; go to IDLE.
REQ-008 Without baud_tick, the FSM, tx and all counters SHALL hold.
REQ-009 Each line bit (start, data, stop) SHALL last exactly one baud_tick interval.
REQ-010 The frame SHALL be 1 + DATA_BITS + STOP_BITS bit periods. Back-to-back grants SHALL insert no extra idle bit beyond ALIGN.
REQ-011 A requester still asserting req after its ack SHALL be served again only after every other asserting requester has been served once.
REQ-012 grant_id SHALL hold its value through IDLE until the next grant.
REQ-013 Any change of data_in after ack SHALL NOT affect the frame in flight.

Reset
REQ-014 With rst_n low, the block SHALL set:
- state IDLE; tx = 1; busy = 0; done = 0; ack = 0; grant_id = 0;
- last_grant = NUM_REQ-1, so requester 0 has first priority;
- counters and shift register = 0.
REQ-015 Reset asserted mid-frame SHALL abort the frame immediately: tx = 1 asynchronously and no done pulse. After release the block returns to IDLE with no pending grant.

Verification
REQ-016 Bench SHALL cover, with baud_tick every 4 clk unless stated:
- Single frame: req=0001, data0=0xA5 → ack=0001 one cycle; tx line 0,1,0,1,0,0,1,0,1,1; done after 10th bit; busy low.
- Round-robin: req=1111 held, bytes 0x11/0x22/0x33/0x44 → grants 0,1,2,3,0 in order, each with exactly one ack pulse.
- Tick on grant edge: req and baud_tick asserted in the same IDLE cycle → start bit begins at the following tick, not the coincident one.
- Stall: baud_tick held low 50 clk mid-DATA → tx and bit_cnt frozen; frame resumes intact.
- Reset mid-frame: rst_n low during data bit 3 → tx=1 immediately, busy=0, no done; next req=0100 → grant_id=2, full frame.
- STOP_BITS=2, DATA_BITS=7, data 0x7F → 10-bit frame ending in two high stop bits; done once.
